// File: rtl/mips_lsu.sv
// Load/store unit: big-endian byte-lane alignment, req/ack memory access, timeout.
// Define MIPS_LSU_UNALIGNED_EN to split misaligned half/word accesses in two.
module mips_lsu #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

`ifdef MIPS_LSU_UNALIGNED_EN
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_ACCESS2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
`endif

   localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic        write_q, write_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic        mem_we_q, mem_we_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;

   logic        legal;
   logic [3:0]  be_base;
   logic [3:0]  be1;
   logic [31:0] repl;
   logic [31:0] wd1;
   logic [63:0] data64;
   logic [7:0]  lane [8];
   logic [2:0]  o;
   logic [31:0] top;
   logic [31:0] ext;
   logic        tmo;

`ifdef MIPS_LSU_UNALIGNED_EN
   logic [31:0] r1_q, r1_d;
   logic [3:0]  be2_q, be2_d;
   logic [31:0] wdata2_q, wdata2_d;
   logic        split_q, split_d;
   logic [7:0]  mask8;
   logic [31:0] left;
   logic [63:0] wide;
   logic        split;
`endif

   // Request decode: lane masks and store data for the first access
   always_comb begin
      be_base = 4'b1111;
      repl    = req_wdata;
      unique case (req_size)
         2'b00: begin
            be_base = 4'b1000;
            repl    = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be_base = 4'b1100;
            repl    = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
`ifdef MIPS_LSU_UNALIGNED_EN
      legal = (req_size != 2'b11);
      mask8 = {be_base, 4'b0000} >> req_addr[1:0];
      left  = req_wdata;
      if (req_size == 2'b00)
         left = {req_wdata[7:0], 24'h0};
      else if (req_size == 2'b01)
         left = {req_wdata[15:0], 16'h0};
      wide  = {left, 32'h0} >> {req_addr[1:0], 3'b000};
      split = (mask8[3:0] != 4'b0000);
      be1   = mask8[7:4];
      wd1   = split ? wide[63:32] : repl;
`else
      legal = (req_size == 2'b00)
           || (req_size == 2'b01 && !req_addr[0])
           || (req_size == 2'b10 && req_addr[1:0] == 2'b00);
      be1   = be_base >> req_addr[1:0];
      wd1   = repl;
`endif
   end

   // Load merge: lanes from one or two words, picked from the byte offset
   always_comb begin
`ifdef MIPS_LSU_UNALIGNED_EN
      data64 = (state_q == S_ACCESS2) ? {r1_q, mem_rdata}
                                      : {mem_rdata, 32'h0};
`else
      data64 = {mem_rdata, 32'h0};
`endif
      for (int i = 0; i < 8; i++)
         lane[i] = data64[63-8*i -: 8];
      o   = {1'b0, off_q};
      top = {lane[o], lane[o+3'd1], lane[o+3'd2], lane[o+3'd3]};
      unique case (size_q)
         2'b00:   ext = {{24{signed_q & top[31]}}, top[31:24]};
         2'b01:   ext = {{16{signed_q & top[31]}}, top[31:16]};
         default: ext = top;
      endcase
   end

   assign tmo = !mem_ack && (cnt_q == TMO_LAST);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      rdata_d     = rdata_q;
      write_d     = write_q;
      size_d      = size_q;
      signed_d    = signed_q;
      off_d       = off_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
`ifdef MIPS_LSU_UNALIGNED_EN
      r1_d        = r1_q;
      be2_d       = be2_q;
      wdata2_d    = wdata2_q;
      split_d     = split_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               write_d  = req_write;
               size_d   = req_size;
               signed_d = req_signed;
               off_d    = req_addr[1:0];
               cnt_d    = 16'd0;
               rdata_d  = 32'h0;
               if (legal) begin
                  state_d     = S_ACCESS;
                  err_d       = 1'b0;
                  mem_addr_d  = {req_addr[31:2], 2'b00};
                  mem_we_d    = req_write;
                  mem_be_d    = be1;
                  mem_wdata_d = wd1;
`ifdef MIPS_LSU_UNALIGNED_EN
                  split_d     = split;
                  be2_d       = mask8[3:0];
                  wdata2_d    = wide[31:0];
`endif
               end else begin
                  state_d = S_RESP;
                  err_d   = 1'b1;
               end
            end
         end
         S_ACCESS: begin
            if (mem_ack) begin
`ifdef MIPS_LSU_UNALIGNED_EN
               if (split_q) begin
                  state_d     = S_ACCESS2;
                  r1_d        = mem_rdata;
                  cnt_d       = 16'd0;
                  mem_addr_d  = mem_addr_q + 32'd4;
                  mem_be_d    = be2_q;
                  mem_wdata_d = wdata2_q;
               end else begin
                  state_d = S_RESP;
                  rdata_d = write_q ? 32'h0 : ext;
               end
`else
               state_d = S_RESP;
               rdata_d = write_q ? 32'h0 : ext;
`endif
            end else if (tmo) begin
               state_d = S_RESP;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
`ifdef MIPS_LSU_UNALIGNED_EN
         S_ACCESS2: begin
            if (mem_ack) begin
               state_d = S_RESP;
               rdata_d = write_q ? 32'h0 : ext;
            end else if (tmo) begin
               state_d = S_RESP;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
`endif
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_b) begin
         state_q     <= S_IDLE;
         cnt_q       <= 16'd0;
         err_q       <= 1'b0;
         rdata_q     <= 32'h0;
         write_q     <= 1'b0;
         size_q      <= 2'b00;
         signed_q    <= 1'b0;
         off_q       <= 2'b00;
         mem_addr_q  <= 32'h0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= 4'h0;
         mem_wdata_q <= 32'h0;
`ifdef MIPS_LSU_UNALIGNED_EN
         r1_q        <= 32'h0;
         be2_q       <= 4'h0;
         wdata2_q    <= 32'h0;
         split_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         write_q     <= write_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         off_q       <= off_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
`ifdef MIPS_LSU_UNALIGNED_EN
         r1_q        <= r1_d;
         be2_q       <= be2_d;
         wdata2_q    <= wdata2_d;
         split_q     <= split_d;
`endif
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_err   = resp_valid & err_q;
   assign resp_rdata = resp_valid ? rdata_q : 32'h0;
`ifdef MIPS_LSU_UNALIGNED_EN
   assign mem_req    = (state_q == S_ACCESS) || (state_q == S_ACCESS2);
`else
   assign mem_req    = (state_q == S_ACCESS);
`endif
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_be     = mem_be_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mips_lsu.sv
// Scoreboard bench for mips_lsu: driver pushes expected responses,
// a negedge monitor pops and compares each resp_valid pulse.
module tb_mips_lsu;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_b = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   int checks = 0;
   int errors = 0;
   logic [32:0] exp_q [$];

   mips_lsu #(.MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_b(rst_b),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_b && resp_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got err=%b rdata=%h expected none",
                     resp_err, resp_rdata);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            chk("resp_err", {31'h0, resp_err}, {31'h0, e[32]});
            chk("resp_rdata", resp_rdata, e[31:0]);
         end
      end
   end

   // ack_at = 0 means never acknowledge (timeout path)
   task automatic txn(input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] ad, input logic [31:0] wd,
                      input bit mem, input int ack_at,
                      input logic [31:0] rd, input logic [3:0] ebe,
                      input logic [31:0] ewd, input logic eerr,
                      input logic [31:0] erd);
      int n;
      @(negedge clk);
      chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = ad;
      req_wdata  = wd;
      req_valid  = 1'b1;
      exp_q.push_back({eerr, erd});
      @(posedge clk);
      #1 req_valid = 1'b0;
      if (mem) begin
         n = (ack_at == 0) ? TMO : ack_at;
         for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            chk("mem_req_hi", {31'h0, mem_req}, 32'h1);
            if (c == 1) begin
               chk("mem_addr", mem_addr, {ad[31:2], 2'b00});
               chk("mem_be", {28'h0, mem_be}, {28'h0, ebe});
               chk("mem_we", {31'h0, mem_we}, {31'h0, wr});
               if (wr) chk("mem_wdata", mem_wdata, ewd);
            end
            if (c == ack_at) begin
               mem_ack   = 1'b1;
               mem_rdata = rd;
               @(posedge clk);
               #1 mem_ack = 1'b0;
            end
         end
      end
      @(negedge clk);
      chk("mem_req_lo", {31'h0, mem_req}, 32'h0);
      chk("resp_valid", {31'h0, resp_valid}, 32'h1);
      @(negedge clk);
      chk("req_ready_after", {31'h0, req_ready}, 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk) rst_b = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
      chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
      chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);

      // wr sz sg addr wdata mem ack rdata be ewdata err erdata
      txn(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 1, 4, 32'h0,
          4'b1111, 32'hDEADBEEF, 0, 32'h0);
      txn(0, 2'b00, 1, 32'h103, 32'h0, 1, 1, 32'h000000F0,
          4'b0001, 32'h0, 0, 32'hFFFFFFF0);
      txn(0, 2'b00, 0, 32'h103, 32'h0, 1, 2, 32'h000000F0,
          4'b0001, 32'h0, 0, 32'h000000F0);
      txn(1, 2'b01, 0, 32'h202, 32'h1234ABCD, 1, 2, 32'h0,
          4'b0011, 32'hABCDABCD, 0, 32'h0);
      txn(1, 2'b00, 0, 32'h101, 32'hFFFFFF55, 1, 1, 32'h0,
          4'b0100, 32'h55555555, 0, 32'h0);
      txn(0, 2'b01, 1, 32'h100, 32'h0, 1, 1, 32'h8001FFFF,
          4'b1100, 32'h0, 0, 32'hFFFF8001);
      txn(0, 2'b01, 0, 32'h102, 32'h0, 1, 3, 32'h12348001,
          4'b0011, 32'h0, 0, 32'h00008001);
      txn(0, 2'b00, 1, 32'h101, 32'h0, 1, 1, 32'h127F3456,
          4'b0100, 32'h0, 0, 32'h0000007F);
`ifndef MIPS_LSU_UNALIGNED_EN
      txn(0, 2'b10, 0, 32'h101, 32'h0, 0, 0, 32'h0,
          4'b0000, 32'h0, 1, 32'h0);
      txn(0, 2'b01, 1, 32'h103, 32'h0, 0, 0, 32'h0,
          4'b0000, 32'h0, 1, 32'h0);
`endif
      txn(0, 2'b11, 0, 32'h100, 32'h0, 0, 0, 32'h0,
          4'b0000, 32'h0, 1, 32'h0);
      // timeout, then ack exactly on the last allowed cycle
      txn(0, 2'b10, 0, 32'h200, 32'h0, 1, 0, 32'h0,
          4'b1111, 32'h0, 1, 32'h0);
      txn(0, 2'b10, 0, 32'h200, 32'h0, 1, TMO, 32'h11223344,
          4'b1111, 32'h0, 0, 32'h11223344);

      // reset in the middle of an access, then a stray ack
      @(negedge clk);
      req_write = 1'b0; req_size = 2'b10; req_addr = 32'h300;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("mid_mem_req", {31'h0, mem_req}, 32'h1);
      rst_b = 1'b1;
      @(posedge clk);
      #1 rst_b = 1'b0;
      @(negedge clk);
      chk("mid_rst_mem_req", {31'h0, mem_req}, 32'h0);
      chk("mid_rst_ready", {31'h0, req_ready}, 32'h1);
      mem_ack = 1'b1;
      mem_rdata = 32'hCAFEF00D;
      @(posedge clk);
      #1 mem_ack = 1'b0;
      @(negedge clk);
      chk("late_ack_resp", {31'h0, resp_valid}, 32'h0);
      chk("late_ack_mem_req", {31'h0, mem_req}, 32'h0);
      chk("late_ack_ready", {31'h0, req_ready}, 32'h1);

      txn(0, 2'b10, 1, 32'h400, 32'h0, 1, 1, 32'h89ABCDEF,
          4'b1111, 32'h0, 0, 32'h89ABCDEF);

`ifdef MIPS_LSU_UNALIGNED_EN
      @(negedge clk);
      req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 32'h102; req_valid = 1'b1;
      exp_q.push_back({1'b0, 32'hAABBCCDD});
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("split1_addr", mem_addr, 32'h100);
      chk("split1_be", {28'h0, mem_be}, 32'h3);
      mem_ack = 1'b1; mem_rdata = 32'h0000AABB;
      @(posedge clk);
      #1 mem_ack = 1'b0;
      @(negedge clk);
      chk("split2_req", {31'h0, mem_req}, 32'h1);
      chk("split2_addr", mem_addr, 32'h104);
      chk("split2_be", {28'h0, mem_be}, 32'hC);
      mem_ack = 1'b1; mem_rdata = 32'hCCDD0000;
      @(posedge clk);
      #1 mem_ack = 1'b0;
      @(negedge clk);
      chk("split_resp", {31'h0, resp_valid}, 32'h1);
`endif

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
